mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Single-port memory arbiter for the 16-bit processor. It shares one synchronous RAM between two requesters:
- the instruction fetch path (read-only);
- the control unit's data path (LDA/STA/PSH/POP loads and stores).

It serialises accesses, hides the RAM read latency behind a valid pulse, and drives a stall line back to the control unit while a data access is pending.

Parameters:
ADDR_W, 10, memory address width
DATA_W, 16, data word width
MEM_LAT, 1, RAM read latency in cycles from the mem_en cycle to valid mem_rdata (legal 1..4)
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request, level; held until if_valid
if_addr  in  ADDR_W  fetch address, stable while if_req=1
if_rdata  out  DATA_W  fetch read data, held until the next fetch completion
if_valid  out  1  one-cycle pulse: if_rdata valid
d_req  in  1  data request, level; held until d_valid
d_we  in  1  1=write, 0=read; stable while d_req=1
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data, held until the next data read completion
d_valid  out  1  one-cycle pulse: data read or write complete
stall  out  1  to control unit: d_req && !d_valid
busy  out  1  state != IDLE
mem_en  out  1  RAM access strobe, one cycle per access
mem_we  out  1  RAM write enable (only when mem_en=1)
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset clears everything at the clock edge:
  - state IDLE;
  - all outputs 0, including the rdata registers;
  - starvation counter 0, latency counter 0.
- Reset mid-operation (ACCESS/WAIT/RESP) aborts the access:
  - no valid pulse is issued;
  - mem_en=0 and busy=0 in the cycle after the reset edge.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is pending, select the winner and register src, addr, we and wdata. Next state is ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive mem_en=1, plus mem_we, mem_addr and mem_wdata from the latched values.
  - Write: next state RESP.
  - Read: load the latency counter with MEM_LAT; next state WAIT.
- WAIT (MEM_LAT cycles):
  - Decrement the counter each cycle.
  - In the last WAIT cycle, capture mem_rdata into if_rdata or d_rdata according to src. Next state RESP.
- RESP (1 cycle):
  - Pulse if_valid or d_valid according to src. Next state IDLE.
  - A requester may change or drop its request from the following cycle; IDLE never sees a stale request.
- Timing, with the request sampled in cycle 0:
  - mem_en in cycle 1;
  - write d_valid in cycle 2;
  - read valid in cycle 2+MEM_LAT.
- Throughput: writes take 3 cycles per access; reads take 3+MEM_LAT.
- Priority:
  - Data beats fetch, because the control unit is stalled on it.
  - The starvation counter increments on each data grant made while if_req=1.
  - It clears on a fetch grant, or in any IDLE cycle with if_req=0.
  - When the counter equals STARVE_MAX and if_req=1, the next grant goes to fetch.
- Writes never alter d_rdata. Fetch never writes (mem_we=0 for src=FETCH).
- A request arriving while busy waits; it is evaluated in the next IDLE cycle.
- Both ports may use the same address; accesses are serialised with no hazard handling.
- stall is combinational; all other outputs are registered or decoded from state/src.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3;
  - source encoding: SRC_FETCH=1'b0, SRC_DATA=1'b1;
  - latency counter width: 3.
- One natural sub-module, mem_arb_select. It is combinational and takes if_req, d_req and starvation count versus STARVE_MAX; it outputs grant_valid and grant_src.
- The FSM, counters and registers stay in mem_arbiter.

Test Plan:
1. MEM_LAT=1; fetch read, if_req=1, if_addr=0x010, RAM returns 0x1234 -> mem_en=1, mem_we=0, mem_addr=0x010 in cycle 1; if_valid=1 with if_rdata=0x1234 in cycle 3; busy low in cycle 4.
2. Data write, d_addr=0x3FF, d_wdata=0xBEEF -> mem_we=1 and mem_wdata=0xBEEF in cycle 1; d_valid in cycle 2; stall=1 in cycles 0-1 and 0 in cycle 2; d_rdata unchanged.
3. if_req and data read (d_addr=0x020) asserted in the same cycle, MEM_LAT=2 -> data granted first (d_valid cycle 4); fetch mem_en in cycle 6; if_valid in cycle 8.
4. STARVE_MAX=4; back-to-back data writes with if_req held high -> exactly 4 data grants, the 5th grant is fetch, then data resumes.
5. MEM_LAT=3; reset pulsed during WAIT -> no if_valid/d_valid pulse; mem_en=0, busy=0, stall follows d_req; a new fetch afterwards completes in 2+MEM_LAT cycles.
6. MEM_LAT=4; data read at 0x001 returning 0xA5A5 -> d_valid with d_rdata=0xA5A5 in cycle 6; stall=1 in cycles 0-5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the single-port memory arbiter.
//   state_t  : arbiter FSM state encoding
//   src_t    : which requester owns the current access
//   LAT_W    : width of the RAM read latency down-counter
//   STARVE_W : width of the fetch starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select
// Combinational grant selection between instruction fetch and data access.
// Data normally wins because the control unit is stalled on it; fetch is
// forced through once STARVE_MAX data grants have been made while it waited.
// Ports:
//   if_req      in  fetch request pending
//   d_req       in  data request pending
//   starve_cnt  in  consecutive data grants made while fetch waited
//   grant_valid out some request can be granted this cycle
//   grant_src   out winning requester (meaningful only with grant_valid)
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_valid,
  output src_t                grant_src
);

  logic starved;

  assign starved = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));

  always_comb begin
    grant_valid = if_req || d_req;
    grant_src   = SRC_FETCH;
    if (d_req && !starved) begin
      grant_src = SRC_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous RAM between the instruction fetch path (read only)
// and the control unit's data path. Accesses are serialised through an
// IDLE -> ACCESS -> (WAIT) -> RESP sequence; the RAM read latency is hidden
// behind a one-cycle valid pulse to the owning requester.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   if_req/if_addr          fetch read request and address
//   if_rdata/if_valid       fetch read data (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, direction, address, write data
//   d_rdata/d_valid         data read data (held) and completion pulse
//   stall                   control unit stall while its request is pending
//   busy                    arbiter is not idle
//   mem_en/mem_we/mem_addr/mem_wdata  RAM access strobe and command
//   mem_rdata               RAM read data, MEM_LAT cycles after mem_en
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state;
  src_t                src;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_valid;
  src_t                grant_src;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .if_req      (if_req),
    .d_req       (d_req),
    .starve_cnt  (starve_cnt),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  // Command outputs come straight from the latched request so the RAM sees
  // a registered address/data; the strobes are decoded from the state.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = (state == RESP) && (src == SRC_FETCH);
  assign d_valid   = (state == RESP) && (src == SRC_DATA);
  assign busy      = (state != IDLE);
  assign stall     = d_req && !d_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src        <= SRC_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            src   <= grant_src;
            state <= ACCESS;
            if (grant_src == SRC_DATA) begin
              addr_q  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_wdata;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
          // Count data grants that overtook a waiting fetch; any fetch
          // grant or a cycle with no fetch pending resets the count.
          if (grant_valid && (grant_src == SRC_FETCH)) begin
            starve_cnt <= '0;
          end else if (!if_req) begin
            starve_cnt <= '0;
          end else if (grant_valid) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state <= RESP;
          end else begin
            lat_cnt <= LAT_W'(MEM_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // The counter reaches 1 in the cycle the RAM presents its data.
          if (lat_cnt == LAT_W'(1)) begin
            if (src == SRC_FETCH) begin
              if_rdata <= mem_rdata;
            end else begin
              d_rdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
